// File: rtl/di_pkg.sv
// Shared definitions for DI register-bus initiators: bus widths and the
// master FSM state encoding.
package di_pkg;

   localparam int unsigned DI_TERM_WIDTH   = 16;
   localparam int unsigned DI_ADDR_WIDTH   = 32;
   localparam int unsigned DI_DATA_WIDTH   = 32;
   localparam int unsigned DI_STATUS_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_WAIT = 3'd1,
      ST_WR_STB  = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RD_STB  = 3'd5,
      ST_RESP    = 3'd6
   } di_state_t;

endpackage

// File: rtl/di_timeout_counter.sv
// Wait-cycle counter for DI initiators. Held at zero while i_clear is high,
// counts enabled cycles and saturates at TIMEOUT. o_expired flags the enabled
// cycle whose increment reaches TIMEOUT, so a waiting FSM leaves after exactly
// TIMEOUT stalled cycles. TIMEOUT=0 never expires.
module di_timeout_counter #(
   parameter int unsigned TIMEOUT  = 1024,
   parameter int unsigned TO_WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam bit                  LP_ENABLED = (TIMEOUT != 32'd0);
   localparam logic [TO_WIDTH-1:0] LP_LIMIT   = TO_WIDTH'(TIMEOUT);
   localparam logic [TO_WIDTH-1:0] LP_LAST    = TO_WIDTH'(TIMEOUT - 32'd1);

   logic [TO_WIDTH-1:0] r_count;

   // Count stalled cycles, saturating at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LP_LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = LP_ENABLED && i_enable && (r_count >= LP_LAST);

endmodule

// File: rtl/di_master.sv
// DI register-bus initiator: accepts one read/write command, runs the DI
// handshake (mode, request, wait for ready, strobe) and returns data/status.
module di_master
   import di_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 1024,
   parameter int unsigned TO_WIDTH = 16
) (
   input  logic                       di_clk,
   input  logic                       resetb,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [DI_TERM_WIDTH-1:0]   cmd_term,
   input  logic [DI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DI_DATA_WIDTH-1:0]   cmd_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DI_DATA_WIDTH-1:0]   rsp_data,
   output logic [DI_STATUS_WIDTH-1:0] rsp_status,
   output logic                       rsp_timeout,
   output logic                       rsp_noterm,
   output logic [DI_TERM_WIDTH-1:0]   di_term_addr,
   output logic [DI_ADDR_WIDTH-1:0]   di_reg_addr,
   output logic                       di_read_mode,
   output logic                       di_read_req,
   output logic                       di_read,
   output logic                       di_write_mode,
   output logic                       di_write,
   output logic [DI_DATA_WIDTH-1:0]   di_reg_datai,
   input  logic                       di_read_rdy,
   input  logic [DI_DATA_WIDTH-1:0]   di_reg_datao,
   input  logic                       di_write_rdy,
   input  logic [DI_STATUS_WIDTH-1:0] di_transfer_status,
   input  logic                       di_en
);

   di_state_t                  r_state;
   di_state_t                  w_state_nxt;
   logic                       r_live;
   logic [DI_TERM_WIDTH-1:0]   r_term;
   logic [DI_ADDR_WIDTH-1:0]   r_addr;
   logic [DI_DATA_WIDTH-1:0]   r_datai;
   logic                       r_wr_mode;
   logic                       r_rd_mode;
   logic [DI_DATA_WIDTH-1:0]   r_rsp_data;
   logic [DI_STATUS_WIDTH-1:0] r_rsp_status;
   logic                       r_rsp_timeout;
   logic                       r_rsp_noterm;

   logic w_accept;
   logic w_in_wait;
   logic w_wait_rdy;
   logic w_expired;
   logic w_timeout_hit;
   logic w_rsp_done;

   assign w_accept      = cmd_valid & cmd_ready;
   assign w_in_wait     = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
   assign w_wait_rdy    = (r_state == ST_WR_WAIT) ? di_write_rdy : di_read_rdy;
   assign w_timeout_hit = w_in_wait & ~w_wait_rdy & w_expired;
   assign w_rsp_done    = (r_state == ST_RESP) & rsp_ready;

   // Counter is held clear outside the wait states, so it starts at zero on
   // every entry; a ready cycle does not count, which lets ready win a tie.
   di_timeout_counter #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (TO_WIDTH)
   ) u_timeout (
      .clk       (di_clk),
      .rst_n     (resetb),
      .i_clear   (~w_in_wait),
      .i_enable  (w_in_wait & ~w_wait_rdy),
      .o_expired (w_expired)
   );

   // State register
   always_ff @(posedge di_clk or negedge resetb) begin
      if (!resetb) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Hold cmd_ready low until the first clock after reset release
   always_ff @(posedge di_clk or negedge resetb) begin
      if (!resetb) r_live <= 1'b0;
      else         r_live <= 1'b1;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_state_nxt = cmd_write ? ST_WR_WAIT : ST_RD_REQ;
         ST_WR_WAIT: begin
            if (di_write_rdy)   w_state_nxt = ST_WR_STB;
            else if (w_expired) w_state_nxt = ST_RESP;
         end
         ST_WR_STB:  w_state_nxt = ST_RESP;
         ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (di_read_rdy)    w_state_nxt = ST_RD_STB;
            else if (w_expired) w_state_nxt = ST_RESP;
         end
         ST_RD_STB:  w_state_nxt = ST_RESP;
         ST_RESP:    if (rsp_ready) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Bus-side registers and response capture
   always_ff @(posedge di_clk or negedge resetb) begin
      if (!resetb) begin
         r_term        <= '0;
         r_addr        <= '0;
         r_datai       <= '0;
         r_wr_mode     <= 1'b0;
         r_rd_mode     <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_status  <= '0;
         r_rsp_timeout <= 1'b0;
         r_rsp_noterm  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_term        <= cmd_term;
            r_addr        <= cmd_addr;
            r_datai       <= cmd_data;
            r_wr_mode     <= cmd_write;
            r_rd_mode     <= ~cmd_write;
            r_rsp_data    <= '0;
            r_rsp_status  <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_noterm  <= 1'b0;
         end
         if (r_state == ST_WR_STB) begin
            r_rsp_status <= di_transfer_status;
            r_rsp_noterm <= ~di_en;
         end
         // Read data from an undecoded terminal is reported as zero
         if (r_state == ST_RD_STB) begin
            r_rsp_data   <= di_en ? di_reg_datao : '0;
            r_rsp_status <= di_transfer_status;
            r_rsp_noterm <= ~di_en;
         end
         if (w_timeout_hit) r_rsp_timeout <= 1'b1;
         if (w_rsp_done) begin
            r_wr_mode <= 1'b0;
            r_rd_mode <= 1'b0;
         end
      end
   end

   assign cmd_ready     = r_live & (r_state == ST_IDLE);
   assign rsp_valid     = (r_state == ST_RESP);
   assign rsp_data      = r_rsp_data;
   assign rsp_status    = r_rsp_status;
   assign rsp_timeout   = r_rsp_timeout;
   assign rsp_noterm    = r_rsp_noterm;
   assign di_term_addr  = r_term;
   assign di_reg_addr   = r_addr;
   assign di_reg_datai  = r_datai;
   assign di_write_mode = r_wr_mode;
   assign di_read_mode  = r_rd_mode;
   assign di_write      = (r_state == ST_WR_STB);
   assign di_read_req   = (r_state == ST_RD_REQ);
   assign di_read       = (r_state == ST_RD_STB);

endmodule

// File: tb/tb_di_master.sv
// Scoreboard bench for di_master: stimulus pushes expected responses, a
// negedge monitor compares every cycle rsp_valid is high and pops on rsp_ready.
module tb_di_master;

   logic        di_clk = 1'b0;
   logic        resetb;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_term;
   logic [31:0] cmd_addr, cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [15:0] rsp_status;
   logic        rsp_timeout, rsp_noterm;
   logic [15:0] di_term_addr;
   logic [31:0] di_reg_addr, di_reg_datai, di_reg_datao;
   logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
   logic        di_read_rdy, di_write_rdy, di_en;
   logic [15:0] di_transfer_status;

   always #5 di_clk = ~di_clk;

   di_master #(.TIMEOUT(8), .TO_WIDTH(16)) dut (
      .di_clk(di_clk), .resetb(resetb),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_term(cmd_term), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .rsp_timeout(rsp_timeout), .rsp_noterm(rsp_noterm),
      .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
      .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
      .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
      .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
      .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status),
      .di_en(di_en)
   );

   typedef struct {
      logic [31:0] data;
      logic [15:0] status;
      logic        timeout;
      logic        noterm;
      logic        wr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_wr = 0, n_rd = 0, n_req = 0, mode_err = 0;
   logic [15:0] cap_term = '0;
   logic [31:0] cap_addr = '0, cap_data = '0;
   int   rise_cyc = 0;
   logic prev_valid = 1'b0;

   function automatic exp_t mk(input logic [31:0] d, input logic [15:0] s,
                               input logic t, input logic n, input logic w);
      exp_t e;
      e.data = d; e.status = s; e.timeout = t; e.noterm = n; e.wr = w;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus observer: cycle count, strobe counts, values at the write strobe
   always @(posedge di_clk) begin
      cyc <= cyc + 1;
      if (di_write) begin
         n_wr     <= n_wr + 1;
         cap_term <= di_term_addr;
         cap_addr <= di_reg_addr;
         cap_data <= di_reg_datai;
      end
      if (di_read)     n_rd  <= n_rd + 1;
      if (di_read_req) n_req <= n_req + 1;
      if (((di_read_req || di_read) && !di_read_mode) || (di_write && !di_write_mode))
         mode_err <= mode_err + 1;
   end

   // Response monitor
   always @(negedge di_clk) begin
      if (resetb && rsp_valid) begin
         if (!prev_valid) rise_cyc = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
         end else begin
            chk("rsp_data",    rsp_data,    sb[0].data);
            chk("rsp_status",  {16'h0, rsp_status}, {16'h0, sb[0].status});
            chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, sb[0].timeout});
            chk("rsp_noterm",  {31'h0, rsp_noterm},  {31'h0, sb[0].noterm});
            chk("rsp_mode",    {30'h0, di_write_mode, di_read_mode},
                               {30'h0, sb[0].wr, ~sb[0].wr});
            if (rsp_ready) void'(sb.pop_front());
         end
      end
      prev_valid = rsp_valid;
   end

   task automatic send(input logic wr, input logic [15:0] term, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold, output int acc);
      bit done = 1'b0;
      acc = -1;
      cmd_write = wr; cmd_term = term; cmd_addr = addr; cmd_data = data;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge di_clk);
         if (cmd_ready) begin
            done = 1'b1;
            acc  = cyc;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept: got no accept in 100 cycles expected accept");
      end
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge di_clk);
         #1;
         if (sb.size() == 0 && !rsp_valid) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_done: got %0d pending responses expected 0", name, sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, a1, a2, ex, w0, r0, q0;
      bit seen, ok, got_rsp;

      resetb = 1'b0; rsp_ready = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_term = '0; cmd_addr = '0; cmd_data = '0;
      di_read_rdy = 1'b0; di_write_rdy = 1'b0; di_en = 1'b1;
      di_reg_datao = '0; di_transfer_status = '0;

      // Reset state
      repeat (2) @(posedge di_clk);
      #1;
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_strobes", {27'h0, di_write_mode, di_read_mode, di_write, di_read, di_read_req}, 32'h0);
      chk("rst_term", {16'h0, di_term_addr}, 32'h0);
      chk("rst_addr", di_reg_addr, 32'h0);
      chk("rst_datai", di_reg_datai, 32'h0);
      chk("rst_rsp", {rsp_status, 14'h0, rsp_timeout, rsp_noterm}, 32'h0);
      resetb = 1'b1;
      #1 chk("rel_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
      @(posedge di_clk); #1;
      chk("rel_cmd_ready_high", {31'h0, cmd_ready}, 32'h1);

      // Write with ready tied high
      di_write_rdy = 1'b1; di_en = 1'b1; di_transfer_status = 16'h0000;
      w0 = n_wr;
      sb.push_back(mk(32'h0, 16'h0, 1'b0, 1'b0, 1'b1));
      send(1'b1, 16'h0010, 32'h4, 32'hDEADBEEF, 1'b0, acc);
      wait_done("wr");
      chk("wr_pulses", n_wr - w0, 1);
      chk("wr_term", {16'h0, cap_term}, 32'h0010);
      chk("wr_addr", cap_addr, 32'h4);
      chk("wr_data", cap_data, 32'hDEADBEEF);
      chk("wr_latency", rise_cyc - acc, 3);

      // Read, ready rises 5 cycles after the request
      di_read_rdy = 1'b0; di_reg_datao = 32'h12345678; di_transfer_status = 16'h0;
      r0 = n_rd; q0 = n_req;
      sb.push_back(mk(32'h12345678, 16'h0, 1'b0, 1'b0, 1'b0));
      send(1'b0, 16'h0011, 32'h8, 32'h0, 1'b0, acc);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge di_clk);
         if (di_read_req) seen = 1'b1;
      end
      chk("rd_req_seen", {31'h0, seen}, 32'h1);
      repeat (4) @(posedge di_clk);
      #1 di_read_rdy = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 40 && !rsp_valid; i++) begin
         @(negedge di_clk);
         if (!di_read_mode) ok = 1'b0;
      end
      chk("rd_mode_held", {31'h0, ok}, 32'h1);
      wait_done("rd");
      di_read_rdy = 1'b0;
      chk("rd_strobes", n_rd - r0, 1);
      chk("rd_reqs", n_req - q0, 1);

      // Write timeout: ready never arrives
      di_write_rdy = 1'b0; di_en = 1'b0; di_transfer_status = 16'h5555;
      w0 = n_wr;
      sb.push_back(mk(32'h0, 16'h0, 1'b1, 1'b0, 1'b1));
      send(1'b1, 16'h0012, 32'hC, 32'h0BAD0BAD, 1'b0, acc);
      wait_done("to");
      chk("to_no_strobe", n_wr - w0, 0);
      chk("to_latency", rise_cyc - acc, 9);

      // Read to an unmapped terminal
      di_read_rdy = 1'b1; di_en = 1'b0; di_transfer_status = 16'h0001; di_reg_datao = 32'h0;
      sb.push_back(mk(32'h0, 16'h0001, 1'b0, 1'b1, 1'b0));
      send(1'b0, 16'h0099, 32'h10, 32'h0, 1'b0, acc);
      wait_done("noterm");
      chk("rd_min_latency", rise_cyc - acc, 4);

      // Back-to-back with a stalled response
      di_write_rdy = 1'b1; di_read_rdy = 1'b1; di_en = 1'b1;
      di_transfer_status = 16'h0003; di_reg_datao = 32'hCAFEF00D;
      rsp_ready = 1'b0; w0 = n_wr; ex = 0; a2 = -1;
      sb.push_back(mk(32'h0, 16'h0003, 1'b0, 1'b0, 1'b1));
      sb.push_back(mk(32'hCAFEF00D, 16'h0003, 1'b0, 1'b0, 1'b0));
      fork
         begin
            send(1'b1, 16'h0020, 32'h8, 32'h11112222, 1'b1, a1);
            send(1'b0, 16'h0021, 32'hC, 32'h0, 1'b0, a2);
         end
         begin
            got_rsp = 1'b0;
            for (int i = 0; i < 50 && !got_rsp; i++) begin
               @(negedge di_clk);
               if (rsp_valid) got_rsp = 1'b1;
            end
            repeat (4) @(posedge di_clk);
            #1 rsp_ready = 1'b1;
            @(posedge di_clk);
            ex = cyc;
         end
      join
      chk("b2b_rsp_seen", {31'h0, got_rsp}, 32'h1);
      chk("b2b_accept_gap", a2 - ex, 1);
      wait_done("b2b");
      chk("b2b_wr_pulses", n_wr - w0, 1);
      chk("b2b_wr_data", cap_data, 32'h11112222);

      // Reset while waiting for read ready
      di_read_rdy = 1'b0; di_en = 1'b1;
      send(1'b0, 16'h0030, 32'h40, 32'h0, 1'b0, acc);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge di_clk);
         if (di_read_req) seen = 1'b1;
      end
      @(posedge di_clk);
      #1 chk("rdwait_mode", {31'h0, di_read_mode}, 32'h1);
      #2 resetb = 1'b0;
      #1;
      chk("arst_strobes", {27'h0, di_write_mode, di_read_mode, di_write, di_read, di_read_req}, 32'h0);
      chk("arst_term", {16'h0, di_term_addr}, 32'h0);
      chk("arst_addr", di_reg_addr, 32'h0);
      chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("arst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      repeat (2) @(posedge di_clk);
      #1 resetb = 1'b1;
      @(posedge di_clk); #1;
      chk("arst_rel_ready", {31'h0, cmd_ready}, 32'h1);
      di_write_rdy = 1'b1; di_transfer_status = 16'h0007;
      w0 = n_wr;
      sb.push_back(mk(32'h0, 16'h0007, 1'b0, 1'b0, 1'b1));
      send(1'b1, 16'h0040, 32'h20, 32'hA5A5A5A5, 1'b0, acc);
      wait_done("post_rst");
      chk("post_rst_latency", rise_cyc - acc, 3);
      chk("post_rst_data", cap_data, 32'hA5A5A5A5);
      chk("post_rst_pulses", n_wr - w0, 1);

      repeat (3) @(posedge di_clk);
      #1;
      chk("sb_empty", sb.size(), 0);
      chk("strobe_mode", mode_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
